fifo_axi_bridge_mc: RTL and testbench
=====================================

Name: fifo_axi_bridge_mc

Overview:
- Multi-channel AXI4-Lite slave bridge that lets the PS pop words from NUM_CH capture FIFOs.
- Adds a register window (enable, sticky timeout status, per-channel pop counters), full AR/R and AW/W/B handshakes, and SLVERR responses.
- Sits between the PS AXI-Lite interconnect and the measurement FIFOs' read ports.

Parameters:
- NUM_CH, 2: number of FIFO channels, 1..8.
- DATA_W, 32: FIFO word width, 1..32; zero-extended onto rdata.
- ADDR_W, 9: AXI address width; only addr[8:2] is decoded.
- TIMEOUT, 255: maximum cycles to wait for fifo_data_in_vld after read_req; 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1 ; s_axi_arready  out  1
- s_axi_rdata  out  32 ; s_axi_rresp  out  2 ; s_axi_rvalid  out  1 ; s_axi_rready  in  1
- s_axi_awaddr  in  ADDR_W ; s_axi_awvalid  in  1 ; s_axi_awready  out  1
- s_axi_wdata  in  32 ; s_axi_wstrb  in  4 ; s_axi_wvalid  in  1 ; s_axi_wready  out  1
- s_axi_bresp  out  2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1
- fifo_data_in  in  NUM_CH*DATA_W  channel ch occupies bits [ch*DATA_W +: DATA_W]
- fifo_data_in_vld  in  NUM_CH  per-channel data valid (may last a single cycle)
- read_req  out  NUM_CH  one-hot, single-cycle pop request

Behaviour:
- Address map (byte offsets):
  - 0x000+4*ch DATA_ch: read pops one word.
  - 0x040 STATUS: bit ch is the sticky timeout flag; write-1-to-clear.
  - 0x044 CTRL: bit ch is the channel enable; reset value all ones.
  - 0x080+4*ch POPCNT_ch: 32-bit wrapping count of successful pops; read-only.
  - Any other offset, or ch >= NUM_CH, is unmapped.
- Reset: all outputs 0 except s_axi_arready=1. read_req=0, STATUS=0, counters=0, CTRL all enabled, both FSMs idle.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid, latch the address and drop arready.
  - Enabled DATA_ch: go to R_REQ.
  - Any other read (registers, unmapped, or disabled DATA_ch): go to R_RESP next cycle with registered data. Registers return OKAY. Unmapped or disabled returns rdata=0 with SLVERR (2'b10), and no pop occurs.
  - R_REQ: read_req[ch]=1 for exactly one cycle; the wait counter starts. Go to R_WAIT.
  - R_WAIT: on fifo_data_in_vld[ch], capture the data (zero-extended), increment POPCNT_ch, respond OKAY, go to R_RESP.
  - R_WAIT timeout: when TIMEOUT cycles elapse without vld, set STATUS[ch], return rdata=0 with SLVERR, go to R_RESP.
  - vld on other channels is ignored. vld arriving in any state other than R_REQ/R_WAIT is ignored.
  - R_RESP: rvalid=1; rdata and rresp held stable until rready; then R_IDLE (arready=1 the following cycle).
- Read latency:
  - AR handshake at cycle T; read_req at T+1.
  - vld at T+1+k (0<=k<=TIMEOUT) gives rvalid at T+2+k; vld sampled in the read_req cycle counts as k=0.
  - Register read: rvalid at T+1.
- Write FSM states: W_IDLE, W_RESP.
  - awready and wready are asserted together for one cycle only when awvalid & wvalid are both high in W_IDLE. The address and data are applied that cycle, then W_RESP.
  - A lone awvalid or a lone wvalid waits.
  - CTRL and STATUS updates require wstrb[0]; bits >= NUM_CH are ignored.
  - Writes to CTRL or STATUS return OKAY. Writes to DATA, POPCNT, or unmapped offsets are ignored and return SLVERR.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
- Read and write paths are independent and may be active in the same cycle.
- Conflicts:
  - A timeout set and a W1C clear of the same STATUS bit in the same cycle: the set wins.
  - Disabling a channel via CTRL while its read is in R_REQ/R_WAIT: the in-flight read completes normally.
- Counter at 0xFFFF_FFFF wraps to 0.
- Reset mid-transaction: the FSMs return to idle immediately, any read_req pulse is cut, and no response is issued for the aborted transfer.

Decomposition:
- Package fifo_axi_bridge_pkg holds:
  - register offsets (DATA_BASE, STATUS_OFS, CTRL_OFS, POPCNT_BASE);
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - read/write FSM state encodings.
- Sub-module fifo_axi_ch_stat is instantiated once per channel. It holds the POPCNT register and STATUS bit, with inputs for inc, set_to, and clr.

Test Plan:
- Reset, then read DATA_0 with ch0 vld 3 cycles after read_req and fifo word 0x1234_5678 -> one read_req[0] pulse; rdata=0x1234_5678, rresp=OKAY; POPCNT_0 reads 1.
- Read DATA_1 with vld never asserted and TIMEOUT=255 -> rvalid exactly 256 cycles after read_req; rresp=SLVERR, rdata=0; STATUS reads 0x2. Writing 0x2 to STATUS then reading it -> 0x0.
- Write CTRL=0x1, then read DATA_1 -> no read_req; SLVERR. Read DATA_0 still returns OKAY.
- Hold rready low for 10 cycles during an OKAY response -> rvalid, rdata, and rresp stable throughout; arready stays low until one cycle after the handshake.
- Present awvalid 2 cycles before wvalid, with the write to offset 0x100 -> no awready until wvalid is high; bresp=SLVERR; no register changes.
- Assert rst during R_WAIT, then deliver a late vld -> read_req=0, rvalid never asserts, POPCNT unchanged at 0.

Source files
------------

// File: rtl/fifo_axi_bridge_pkg.sv
// fifo_axi_bridge_pkg: register map, response codes and FSM
// encodings shared by the multi-channel FIFO AXI-Lite bridge.
package fifo_axi_bridge_pkg;
  localparam logic [8:0] DATA_BASE   = 9'h000;
  localparam logic [8:0] STATUS_OFS  = 9'h040;
  localparam logic [8:0] CTRL_OFS    = 9'h044;
  localparam logic [8:0] POPCNT_BASE = 9'h080;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_POPCNT,
    REG_NONE
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] ch;
  } reg_sel_t;

  function automatic reg_sel_t reg_decode(
    input logic [8:0] a,
    input int         num_ch
  );
    reg_sel_t s;
    s.ch   = a[4:2];
    s.kind = REG_NONE;
    if (a[8:6] == DATA_BASE[8:6] &&
        int'(a[5:2]) < num_ch)
      s.kind = REG_DATA;
    else if (a[8:2] == STATUS_OFS[8:2])
      s.kind = REG_STATUS;
    else if (a[8:2] == CTRL_OFS[8:2])
      s.kind = REG_CTRL;
    else if (a[8:6] == POPCNT_BASE[8:6] &&
             int'(a[5:2]) < num_ch)
      s.kind = REG_POPCNT;
    return s;
  endfunction
endpackage

// File: rtl/fifo_axi_ch_stat.sv
// fifo_axi_ch_stat: per-channel pop counter and sticky
// timeout flag; a timeout set beats a same-cycle clear.
module fifo_axi_ch_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        set_to,
  input  logic        clr,
  output logic [31:0] popcnt,
  output logic        status
);
  always_ff @(posedge clk) begin
    if (rst) begin
      popcnt <= '0;
      status <= 1'b0;
    end else begin
      if (inc)
        popcnt <= popcnt + 32'd1;
      if (set_to)
        status <= 1'b1;
      else if (clr)
        status <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_axi_bridge_mc.sv
// fifo_axi_bridge_mc: AXI4-Lite slave that pops words from
// NUM_CH capture FIFOs, with enable/status/pop-count registers.
module fifo_axi_bridge_mc
  import fifo_axi_bridge_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data_in,
  input  logic [NUM_CH-1:0]        fifo_data_in_vld,
  output logic [NUM_CH-1:0]        read_req
);
  rd_state_e r_state, r_next;
  wr_state_e w_state, w_next;
  reg_sel_t ar_sel, aw_sel;
  logic [2:0] r_ch;
  logic [15:0] wait_cnt;
  logic [31:0] rdata_q, reg_rd_data;
  logic [1:0] rresp_q, bresp_q;
  logic reg_rd_ok, ar_en, sel_vld;
  logic ar_fire, w_fire, timed_out, pending;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_CH-1:0] ctrl_q, status;
  logic [NUM_CH-1:0] inc, set_to, clr;
  logic [31:0] popcnt [NUM_CH];
  logic unused;

  assign ar_sel = reg_decode(s_axi_araddr[8:0], NUM_CH);
  assign aw_sel = reg_decode(s_axi_awaddr[8:0], NUM_CH);
  assign unused = ^{s_axi_wstrb[3:1], s_axi_wdata};

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_bresp = bresp_q;

  assign ar_fire = (r_state == R_IDLE) && s_axi_arvalid;
  assign pending = (r_state == R_REQ) || (r_state == R_WAIT);
  assign timed_out = (r_state == R_WAIT) && !sel_vld &&
                     (wait_cnt == 16'(TIMEOUT));

  always_comb begin
    reg_rd_data = '0;
    reg_rd_ok   = 1'b1;
    ar_en       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ar_sel.ch == 3'(i)) begin
        ar_en = ctrl_q[i];
        if (ar_sel.kind == REG_POPCNT)
          reg_rd_data = popcnt[i];
      end
    end
    unique case (1'b1)
      ar_sel.kind == REG_STATUS:
        reg_rd_data[NUM_CH-1:0] = status;
      ar_sel.kind == REG_CTRL:
        reg_rd_data[NUM_CH-1:0] = ctrl_q;
      ar_sel.kind == REG_POPCNT: ;
      default: reg_rd_ok = 1'b0;
    endcase
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == 3'(i)) begin
        sel_vld  = fifo_data_in_vld[i];
        sel_data = fifo_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    read_req      = '0;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid)
          r_next = (ar_sel.kind == REG_DATA && ar_en) ?
                   R_REQ : R_RESP;
      end
      R_REQ: begin
        for (int i = 0; i < NUM_CH; i++)
          read_req[i] = (r_ch == 3'(i));
        r_next = sel_vld ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        if (sel_vld || timed_out)
          r_next = R_RESP;
      end
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      r_ch     <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        r_ch    <= ar_sel.ch;
        rdata_q <= reg_rd_ok ? reg_rd_data : '0;
        rresp_q <= reg_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      // wait_cnt tracks k, the cycles since read_req
      if (r_state == R_REQ)
        wait_cnt <= 16'd1;
      else if (r_state == R_WAIT)
        wait_cnt <= wait_cnt + 16'd1;
      if (pending && sel_vld) begin
        rdata_q <= 32'(sel_data);
        rresp_q <= RESP_OKAY;
      end else if (timed_out) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  assign w_fire = (w_state == W_IDLE) &&
                  s_axi_awvalid && s_axi_wvalid;

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = w_fire;
        s_axi_wready  = w_fire;
        if (w_fire)
          w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      bresp_q <= RESP_OKAY;
      ctrl_q  <= '1;
    end else begin
      w_state <= w_next;
      if (w_fire) begin
        bresp_q <= (aw_sel.kind == REG_CTRL ||
                    aw_sel.kind == REG_STATUS) ?
                   RESP_OKAY : RESP_SLVERR;
        if (aw_sel.kind == REG_CTRL && s_axi_wstrb[0])
          ctrl_q <= s_axi_wdata[NUM_CH-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]    = pending && sel_vld && (r_ch == 3'(i));
      set_to[i] = timed_out && (r_ch == 3'(i));
      clr[i]    = w_fire && (aw_sel.kind == REG_STATUS) &&
                  s_axi_wstrb[0] && s_axi_wdata[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_axi_ch_stat u_stat (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[g]),
      .set_to (set_to[g]),
      .clr    (clr[g]),
      .popcnt (popcnt[g]),
      .status (status[g])
    );
  end
endmodule

// File: tb/tb_fifo_axi_bridge_mc.sv
// tb_fifo_axi_bridge_mc: directed bench for the FIFO AXI-Lite
// bridge with hand-computed expectations.
module tb_fifo_axi_bridge_mc;
  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 255;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] araddr = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic arvalid = 1'b0;
  logic rready  = 1'b0;
  logic awvalid = 1'b0;
  logic wvalid  = 1'b0;
  logic bready  = 1'b0;
  logic arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [31:0] wdata = '0;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb = '0;
  logic [NUM_CH*DATA_W-1:0] fdata = '0;
  logic [NUM_CH-1:0] fvld = '0;
  logic [NUM_CH-1:0] read_req;

  int checks = 0;
  int failures = 0;
  int rq0 = 0;
  int rq1 = 0;
  int rv_cnt = 0;
  int rv0 = 0;
  time t_hs = 0;

  always #5 clk = ~clk;

  fifo_axi_bridge_mc #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axi_araddr     (araddr),
    .s_axi_arvalid    (arvalid),
    .s_axi_arready    (arready),
    .s_axi_rdata      (rdata),
    .s_axi_rresp      (rresp),
    .s_axi_rvalid     (rvalid),
    .s_axi_rready     (rready),
    .s_axi_awaddr     (awaddr),
    .s_axi_awvalid    (awvalid),
    .s_axi_awready    (awready),
    .s_axi_wdata      (wdata),
    .s_axi_wstrb      (wstrb),
    .s_axi_wvalid     (wvalid),
    .s_axi_wready     (wready),
    .s_axi_bresp      (bresp),
    .s_axi_bvalid     (bvalid),
    .s_axi_bready     (bready),
    .fifo_data_in     (fdata),
    .fifo_data_in_vld (fvld),
    .read_req         (read_req)
  );

  always @(negedge clk) begin
    if (read_req[0]) rq0++;
    if (read_req[1]) rq1++;
    if (rvalid) rv_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic ar_send(input logic [8:0] a);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", 32'(arready), 32'd1);
    @(posedge clk);
    t_hs = $time;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic r_done(input string tag,
                        input logic [31:0] ed,
                        input logic [1:0] er,
                        input int elat,
                        input int hold);
    int n = 0;
    int lat;
    while (!rvalid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    lat = int'(($time - t_hs + 5) / 10);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, 32'(rresp), 32'(er));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      chk({tag, "_hold_rdata"}, rdata, ed);
      chk({tag, "_hold_rresp"}, 32'(rresp), 32'(er));
      chk({tag, "_hold_arready"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, "_ar_reopen"}, 32'(arready), 32'd1);
  endtask

  task automatic rd_reg(input logic [8:0] a,
                        input logic [31:0] ed,
                        input logic [1:0] er,
                        input string tag);
    ar_send(a);
    r_done(tag, ed, er, 1, 0);
  endtask

  task automatic wr(input logic [8:0] a,
                    input logic [31:0] dd,
                    input logic [3:0] s,
                    input int lead,
                    input logic [1:0] eb,
                    input string tag);
    int n = 0;
    awaddr  = a;
    wdata   = dd;
    wstrb   = s;
    awvalid = 1'b1;
    repeat (lead) begin
      @(negedge clk);
      chk({tag, "_aw_wait"},
          32'({awready, wready}), 32'd0);
    end
    wvalid = 1'b1;
    #1;
    chk({tag, "_aw_rdy"}, 32'({awready, wready}), 32'd3);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), 32'(eb));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_bdone"}, 32'(bvalid), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_read_req", 32'(read_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    rd_reg(9'h044, 32'h3, OKAY, "ctrl_rst");
    rd_reg(9'h040, 32'h0, OKAY, "status_rst");

    // DATA_0, ch0 vld at k=3, stray ch1 vld at k=1
    ar_send(9'h000);
    chk("d0_req", 32'(read_req), 32'h1);
    @(negedge clk);
    fvld = 2'b10;
    fdata[32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    fvld = 2'b00;
    @(negedge clk);
    fvld = 2'b01;
    fdata[0 +: 32] = 32'h1234_5678;
    @(negedge clk);
    fvld = 2'b00;
    r_done("d0", 32'h1234_5678, OKAY, 5, 0);
    chk("d0_pulses", 32'(rq0), 32'd1);
    rd_reg(9'h080, 32'd1, OKAY, "popcnt0_a");
    rd_reg(9'h084, 32'd0, OKAY, "popcnt1_a");

    // DATA_1 timeout: rvalid at T+2+TIMEOUT
    ar_send(9'h004);
    r_done("d1_to", 32'h0, SLVERR, TIMEOUT + 2, 0);
    chk("d1_pulses", 32'(rq1), 32'd1);
    rd_reg(9'h040, 32'h2, OKAY, "status_to");
    rd_reg(9'h084, 32'd0, OKAY, "popcnt1_to");
    wr(9'h040, 32'h2, 4'hF, 0, OKAY, "w1c");
    rd_reg(9'h040, 32'h0, OKAY, "status_clr");

    // disable ch1
    wr(9'h044, 32'h1, 4'h1, 0, OKAY, "ctrl_w");
    rd_reg(9'h044, 32'h1, OKAY, "ctrl_1");
    rd_reg(9'h004, 32'h0, SLVERR, "d1_dis");
    chk("d1_dis_pulses", 32'(rq1), 32'd1);

    // DATA_0 with vld in the read_req cycle (k=0)
    ar_send(9'h000);
    fvld = 2'b01;
    fdata[0 +: 32] = 32'h0000_00A5;
    @(negedge clk);
    fvld = 2'b00;
    r_done("d0_k0", 32'h0000_00A5, OKAY, 2, 0);
    chk("d0_k0_pulses", 32'(rq0), 32'd2);

    // rready held low for 10 cycles
    ar_send(9'h080);
    r_done("stall", 32'd2, OKAY, 1, 10);

    wr(9'h044, 32'h0, 4'hE, 0, OKAY, "ctrl_nostrb");
    rd_reg(9'h044, 32'h1, OKAY, "ctrl_keep");

    wr(9'h100, 32'hFFFF_FFFF, 4'hF, 2, SLVERR, "w_unmap");
    wr(9'h000, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, "w_data");
    wr(9'h080, 32'h0, 4'hF, 0, SLVERR, "w_popcnt");
    rd_reg(9'h044, 32'h1, OKAY, "ctrl_after");
    rd_reg(9'h040, 32'h0, OKAY, "status_after");
    rd_reg(9'h080, 32'd2, OKAY, "popcnt_after");
    rd_reg(9'h100, 32'h0, SLVERR, "r_unmap");
    rd_reg(9'h008, 32'h0, SLVERR, "r_ch2");
    rd_reg(9'h088, 32'h0, SLVERR, "r_pc2");

    // reset while in R_WAIT, then a late vld
    ar_send(9'h000);
    rv0 = rv_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 32'(read_req), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    rst = 1'b0;
    fvld = 2'b01;
    fdata[0 +: 32] = 32'h0000_0055;
    @(negedge clk);
    fvld = 2'b00;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_resp", 32'(rv_cnt), 32'(rv0));
    chk("mid_rst_pulses", 32'(rq0), 32'd3);
    rd_reg(9'h080, 32'd0, OKAY, "popcnt_rst");
    rd_reg(9'h044, 32'h3, OKAY, "ctrl_rst2");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
